phy_reset_seq: RTL and testbench

Parametrised PHY reset sequencer: holds an external PHY in reset for a programmable time after FPGA reset or on request, waits a programmable settle interval, then flags the link as ready. It sits in the TCXO clock domain at chip level. Its `phy_reset` output feeds the open-drain `phy_nreset` driver, and `ready` gates MDIO/RGMII start-up logic. Over a fixed power-up holdoff it adds retriggerable manual resets, a settle phase, an optional no-auto-start mode and a request counter.

---
 rtl/phy_reset_seq_pkg.sv | 16 +
 rtl/phy_reset_seq_if.sv | 10 +
 rtl/phy_reset_seq.sv | 45 ++++
 tb/tb_phy_reset_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/phy_reset_seq_pkg.sv
// phy_reset_seq_pkg: shared state encoding and default timing for the PHY reset sequencer
package phy_reset_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ASSERT = ST_ASSERT,
    SETTLE = ST_SETTLE,
    READY = ST_READY
  } state_t;
  localparam int DEF_CW = 24;
  localparam int DEF_T_ASSERT = 16000000;
  localparam int DEF_T_SETTLE = 777600;
endpackage

// File: rtl/phy_reset_seq_if.sv
// phy_reset_seq_if: request and status signals of the PHY reset sequencer
interface phy_reset_seq_if;
  logic req;
  logic phy_reset;
  logic ready;
  logic busy;
  logic [7:0] req_count;
  modport master(output req, input phy_reset, ready, busy, req_count);
  modport slave(input req, output phy_reset, ready, busy, req_count);
endinterface

// File: rtl/phy_reset_seq.sv
// phy_reset_seq: holds the PHY in reset, waits a settle interval, then flags ready
module phy_reset_seq
  import phy_reset_seq_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int T_ASSERT = DEF_T_ASSERT,
  parameter int T_SETTLE = DEF_T_SETTLE,
  parameter int AUTO_START = 1
) (
  input logic clk,
  input logic reset,
  phy_reset_seq_if.slave bus
);
  if (T_ASSERT < 1 || T_ASSERT >= 2 ** CW || T_SETTLE < 1 || T_SETTLE >= 2 ** CW) begin : g_bad_params
    $error("phy_reset_seq: T_ASSERT and T_SETTLE must lie in [1, 2**CW)");
  end
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic req_d;
  logic [7:0] req_count;
  logic ta, ts;
  always_comb begin
    ta = state == ASSERT && cnt == CW'(T_ASSERT - 1);
    ts = state == SETTLE && cnt == CW'(T_SETTLE - 1);
    nxt = bus.req ? ASSERT : ta ? SETTLE : ts ? READY : state;
    cnt_nxt = (bus.req || ta || ts || state == IDLE || state == READY) ? '0 : cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AUTO_START != 0 ? ASSERT : IDLE;
      cnt <= '0;
      req_d <= 1'b0;
      req_count <= 8'd0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      req_d <= bus.req;
      if (bus.req && !req_d && req_count != 8'hff) req_count <= req_count + 8'd1;
    end
  end
  assign bus.phy_reset = state == ASSERT;
  assign bus.busy = state == ASSERT || state == SETTLE;
  assign bus.ready = state == READY;
  assign bus.req_count = req_count;
endmodule

// File: tb/tb_phy_reset_seq.sv
// tb_phy_reset_seq: randomized and directed checks of both start modes against a timestamp model
module tb_phy_reset_seq;
  localparam int TA = 10;
  localparam int TS = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  int checks = 0;
  int errors = 0;
  int since[2];
  bit started[2];
  int rc = 0;
  bit prev = 0;
  logic [10:0] exp0, exp1, o0, o1;
  phy_reset_seq_if if0();
  phy_reset_seq_if if1();
  assign if0.req = req;
  assign if1.req = req;
  assign o0 = {if0.phy_reset, if0.busy, if0.ready, if0.req_count};
  assign o1 = {if1.phy_reset, if1.busy, if1.ready, if1.req_count};
  phy_reset_seq #(.CW(8), .T_ASSERT(TA), .T_SETTLE(TS), .AUTO_START(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  phy_reset_seq #(.CW(8), .T_ASSERT(TA), .T_SETTLE(TS), .AUTO_START(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  always #5 clk = ~clk;
  function automatic logic [10:0] expect_out(input int i);
    return {started[i] && since[i] < TA, started[i] && since[i] < TA + TS, started[i] && since[i] >= TA + TS, 8'(rc)};
  endfunction
  task automatic cycle(input bit r, input bit rs);
    req = r;
    reset = rs;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        started[i] = (i == 1);
        since[i] = 0;
      end else if (r) begin
        started[i] = 1;
        since[i] = 0;
      end else if (since[i] < 100000) since[i]++;
    end
    if (rs) begin
      rc = 0;
      prev = 0;
    end else begin
      if (r && !prev && rc < 255) rc++;
      prev = r;
    end
    exp0 = expect_out(0);
    exp1 = expect_out(1);
    #1;
  endtask
  task automatic test_reset();
    repeat (3) cycle(0, 1);
    checks += 2;
    if (o0 !== 11'h000) begin errors++; $display("FAIL reset dut0 got %h exp %h", o0, 11'h000); end
    if (o1 !== 11'h600) begin errors++; $display("FAIL reset dut1 got %h exp %h", o1, 11'h600); end
  endtask
  task automatic test_power_up();
    for (int c = 0; c < TA + TS + 5; c++) begin
      cycle(0, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL power_up dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL power_up dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
  endtask
  task automatic test_idle_then_req();
    for (int c = 0; c < 50 + 1 + TA + TS + 5; c++) begin
      cycle(c == 50, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL idle_req dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL idle_req dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
    checks++;
    if (if0.req_count !== 8'd1) begin errors++; $display("FAIL idle_req count got %0d exp 1", if0.req_count); end
  endtask
  task automatic test_retrigger();
    int p1, p2, n;
    p1 = 1 + TA + 2;
    p2 = p1 + 1 + 7;
    n = p2 + 1 + TA + TS + 3;
    for (int c = 0; c < n; c++) begin
      cycle(c == 0 || c == p1 || c == p2, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL retrigger dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL retrigger dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
  endtask
  task automatic test_simultaneous();
    for (int c = 0; c < 1 + TA - 1 + 1 + TA + TS + 2; c++) begin
      cycle(c == 0 || c == TA, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL simultaneous dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL simultaneous dut1 cyc %0d got %h exp %h", c, o1, exp1); end
      if (c == TA + 1) begin
        checks++;
        if ({if1.phy_reset, if1.busy, if1.ready} !== 3'b110) begin
          errors++;
          $display("FAIL simultaneous hold got %b exp 110", {if1.phy_reset, if1.busy, if1.ready});
        end
      end
    end
  endtask
  task automatic test_long_req();
    int base;
    cycle(0, 0);
    base = rc;
    for (int c = 0; c < 40 + TA + TS + 4; c++) begin
      cycle(c < 40, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL long_req dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL long_req dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
    checks++;
    if (int'(if1.req_count) !== base + 1) begin errors++; $display("FAIL long_req count got %0d exp %0d", if1.req_count, base + 1); end
  endtask
  task automatic test_random();
    bit r = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 11) == 0) r = ~r;
      cycle(r, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL random dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL random dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
  endtask
  task automatic test_saturation_reset();
    for (int c = 0; c < 600 + TA + 2; c++) begin
      cycle(c < 600 && c % 2 == 0, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL saturation dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL saturation dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
    checks++;
    if (if1.req_count !== 8'd255) begin errors++; $display("FAIL saturation count got %0d exp 255", if1.req_count); end
    checks++;
    if ({if1.phy_reset, if1.busy, if1.ready} !== 3'b010) begin errors++; $display("FAIL saturation settle got %b exp 010", {if1.phy_reset, if1.busy, if1.ready}); end
    cycle(0, 1);
    checks += 2;
    if (o0 !== 11'h000) begin errors++; $display("FAIL mid_reset dut0 got %h exp %h", o0, 11'h000); end
    if (o1 !== 11'h600) begin errors++; $display("FAIL mid_reset dut1 got %h exp %h", o1, 11'h600); end
    for (int c = 0; c < TA + TS + 3; c++) begin
      cycle(0, 0);
      checks += 2;
      if (o0 !== exp0) begin errors++; $display("FAIL after_reset dut0 cyc %0d got %h exp %h", c, o0, exp0); end
      if (o1 !== exp1) begin errors++; $display("FAIL after_reset dut1 cyc %0d got %h exp %h", c, o1, exp1); end
    end
  endtask
  initial begin
    test_reset();
    test_power_up();
    test_idle_then_req();
    test_retrigger();
    test_simultaneous();
    test_long_req();
    test_random();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
